// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between FU completion ports.
// Each source owns a 1-entry holding register. Held records are granted
// round-robin onto the CDB. A source can be refilled in the same cycle its
// record departs, so an always-granted source sustains one record per cycle.
// Optional statistics counters are enabled by defining CDB_ARB_STATS_EN.
module cdb_arbiter #(
  parameter int N_SRC     = 4,
  parameter int PAYLOAD_W = 256,
  parameter int IDX_W     = $clog2(N_SRC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*PAYLOAD_W-1:0] src_payload,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       cdb_valid,
  output logic [PAYLOAD_W-1:0]       cdb_payload,
  output logic [IDX_W-1:0]           cdb_src,
  input  logic                       cdb_ready,
  output logic [N_SRC-1:0]           held_mask
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                conflict_cnt,
  output logic [N_SRC*32-1:0]        grant_cnt
`endif
);

  logic [N_SRC-1:0]     held_q, held_d;
  logic [PAYLOAD_W-1:0] hold_data_q [N_SRC];
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]     grant;
  logic                 found;
  logic [IDX_W:0]       scan_idx;
  logic                 xfer;
  logic [IDX_W-1:0]     rr_next;
  logic [N_SRC-1:0]     accept;

  // Rotating priority scan: first held source at or after rr_ptr wins.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(N_SRC)) begin
        scan_idx = scan_idx - (IDX_W+1)'(N_SRC);
      end
      if (!found && held_q[scan_idx[IDX_W-1:0]]) begin
        grant = scan_idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  // CDB drive, transfer detect and per-source accept handshake.
  always_comb begin
    cdb_valid   = |held_q;
    cdb_payload = cdb_valid ? hold_data_q[grant] : '0;
    cdb_src     = cdb_valid ? grant : '0;
    xfer        = cdb_valid && cdb_ready;
    rr_next     = (grant == IDX_W'(N_SRC-1)) ? '0 : grant + 1'b1;
    held_mask   = held_q;
    for (int i = 0; i < N_SRC; i++) begin
      // Held in reset so no FU hands off a record that would be lost.
      src_ready[i] = !rst && !flush &&
                     (!held_q[i] || (xfer && (grant == IDX_W'(i))));
      accept[i]    = src_valid[i] && src_ready[i];
    end
  end

  // Next occupancy and round-robin pointer; flush empties all entries but
  // leaves the pointer where it was.
  always_comb begin
    held_d   = held_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      held_d[grant] = 1'b0;
      rr_ptr_d      = rr_next;
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i]) begin
        held_d[i] = 1'b1;
      end
    end
    if (flush) begin
      held_d   = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Occupancy, pointer and holding-register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q      <= '0;
      rr_ptr_q    <= '0;
      hold_data_q <= '{default: '0};
    end else begin
      held_q   <= held_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N_SRC; i++) begin
        if (accept[i]) begin
          hold_data_q[i] <= src_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] conflict_cnt_q;
  logic [31:0] grant_cnt_q [N_SRC];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Transfer statistics; flush does not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      grant_cnt_q    <= '{default: '0};
    end else if (xfer) begin
      if ($countones(held_q) >= 2) begin
        conflict_cnt_q <= sat_inc(conflict_cnt_q);
      end
      grant_cnt_q[grant] <= sat_inc(grant_cnt_q[grant]);
    end
  end

  // Flatten the per-source grant counters onto the output bus.
  always_comb begin
    conflict_cnt = conflict_cnt_q;
    for (int i = 0; i < N_SRC; i++) begin
      grant_cnt[i*32 +: 32] = grant_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (N_SRC=4, PAYLOAD_W=256).
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int PW = 256;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N*PW-1:0] src_payload;
  logic [N-1:0]    src_ready;
  logic            cdb_valid;
  logic [PW-1:0]   cdb_payload;
  logic [IW-1:0]   cdb_src;
  logic            cdb_ready;
  logic [N-1:0]    held_mask;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]     conflict_cnt;
  logic [N*32-1:0] grant_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_data [N];

  cdb_arbiter #(.N_SRC(N), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_payload(src_payload), .src_ready(src_ready),
    .cdb_valid(cdb_valid), .cdb_payload(cdb_payload), .cdb_src(cdb_src),
    .cdb_ready(cdb_ready), .held_mask(held_mask)
`ifdef CDB_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [PW-1:0] mk(input int s, input int c);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(c * 16 + s);
    return {8{w}};
  endfunction

  task automatic set_pl(input int s, input logic [PW-1:0] v);
    src_payload[s*PW +: PW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Producers must never offer a record the arbiter cannot take (flush excepted).
  always @(negedge clk) begin
    if (!rst && !flush) begin
      n_assert++;
      assert ((src_valid & ~src_ready) === '0) else begin
        n_fail++;
        $error("FAIL proto: valid %b ready %b", src_valid, src_ready);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; src_valid = '0; cdb_ready = 1'b0; src_payload = '0;
    #2;
    check("rst_valid", PW'(cdb_valid), PW'(0));
    check("rst_held", PW'(held_mask), PW'(0));
    check("rst_ready", PW'(src_ready), PW'(0));
    check("rst_payload", cdb_payload, PW'(0));
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_ready", PW'(src_ready), PW'(4'hF));

    // Single source, 1-cycle latency
    src_valid = 4'b0010; set_pl(1, rep(8'hA5)); cdb_ready = 1'b1;
    settle(); tick();
    src_valid = '0; settle();
    check("single_valid", PW'(cdb_valid), PW'(1));
    check("single_src", PW'(cdb_src), PW'(1));
    check("single_payload", cdb_payload, rep(8'hA5));
    check("single_held", PW'(held_mask), PW'(4'b0010));
    tick(); settle();
    check("single_empty_valid", PW'(cdb_valid), PW'(0));
    check("single_empty_payload", cdb_payload, PW'(0));
    check("single_empty_src", PW'(cdb_src), PW'(0));

    // Pointer now at 2: with 1 and 3 held, 3 wins first
    src_valid = 4'b1010; set_pl(1, mk(1, 1)); set_pl(3, mk(3, 1)); cdb_ready = 1'b0;
    settle(); tick();
    src_valid = '0; settle();
    check("ptr2_src", PW'(cdb_src), PW'(3));
    check("ptr2_payload", cdb_payload, mk(3, 1));
    cdb_ready = 1'b1; settle(); tick(); settle();
    check("ptr2_next_src", PW'(cdb_src), PW'(1));
    check("ptr2_next_payload", cdb_payload, mk(1, 1));
    tick(); settle();
    check("ptr2_drained", PW'(cdb_valid), PW'(0));

    // Reset mid-traffic (pointer at 2)
    src_valid = 4'b0101; set_pl(0, mk(0, 2)); set_pl(2, mk(2, 2)); cdb_ready = 1'b0;
    settle(); tick();
    src_valid = '0; settle();
    check("mid_held", PW'(held_mask), PW'(4'b0101));
    check("mid_src", PW'(cdb_src), PW'(2));
    rst = 1'b1; settle();
    check("async_rst_valid", PW'(cdb_valid), PW'(0));
    check("async_rst_held", PW'(held_mask), PW'(0));
    check("async_rst_ready", PW'(src_ready), PW'(0));
    check("async_rst_src", PW'(cdb_src), PW'(0));
    check("async_rst_payload", cdb_payload, PW'(0));
    tick();
    rst = 1'b0; settle();

    // Round-robin with all sources kept full
    src_valid = 4'hF; cdb_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_pl(i, mk(i, 10)); exp_data[i] = mk(i, 10);
    end
    settle(); tick();
    for (int k = 0; k < 8; k++) begin
      src_valid = '0; settle();
      check($sformatf("rr_src_%0d", k), PW'(cdb_src), PW'(k % N));
      check($sformatf("rr_payload_%0d", k), cdb_payload, exp_data[k % N]);
      check($sformatf("rr_ready_%0d", k), PW'(src_ready), PW'(4'b0001 << (k % N)));
      src_valid = 4'b0001 << (k % N);
      set_pl(k % N, mk(k % N, 20 + k)); exp_data[k % N] = mk(k % N, 20 + k);
      settle(); tick();
    end
    src_valid = '0;
    for (int k = 0; k < N; k++) begin
      settle();
      check($sformatf("rr_drain_src_%0d", k), PW'(cdb_src), PW'(k));
      tick();
    end
    settle();
    check("rr_drained", PW'(cdb_valid), PW'(0));

    // Back-pressure: sources 0 and 3 held, writeback stalled
    src_valid = 4'b1001; set_pl(0, mk(0, 30)); set_pl(3, mk(3, 30)); cdb_ready = 1'b0;
    settle(); tick();
    src_valid = '0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("bp_src_%0d", k), PW'(cdb_src), PW'(0));
      check($sformatf("bp_payload_%0d", k), cdb_payload, mk(0, 30));
      check($sformatf("bp_ready_%0d", k), PW'(src_ready), PW'(4'b0110));
      tick();
    end
    cdb_ready = 1'b1; settle();
    check("bp_release_src0", PW'(cdb_src), PW'(0));
    tick(); settle();
    check("bp_release_src3", PW'(cdb_src), PW'(3));
    check("bp_release_payload3", cdb_payload, mk(3, 30));
    tick(); settle();
    check("bp_drained", PW'(cdb_valid), PW'(0));

    // Same-cycle replace on source 2
    src_valid = 4'b0100; set_pl(2, mk(2, 50)); cdb_ready = 1'b1;
    settle(); tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("rep_src_%0d", k), PW'(cdb_src), PW'(2));
      check($sformatf("rep_payload_%0d", k), cdb_payload, mk(2, 50 + k));
      check($sformatf("rep_ready_%0d", k), PW'(src_ready[2]), PW'(1));
      set_pl(2, mk(2, 51 + k));
      settle(); tick();
    end
    src_valid = '0; settle();
    check("rep_last_payload", cdb_payload, mk(2, 54));
    tick(); settle();
    check("rep_drained", PW'(cdb_valid), PW'(0));

    // Fresh reset, then flush with sources 1 and 2 held
    rst = 1'b1; settle(); tick();
    rst = 1'b0; settle();
    src_valid = 4'b0110; set_pl(1, mk(1, 40)); set_pl(2, mk(2, 40)); cdb_ready = 1'b0;
    settle(); tick();
    src_valid = '0; settle();
    check("fl_held", PW'(held_mask), PW'(4'b0110));
    flush = 1'b1; src_valid = 4'b0001; set_pl(0, mk(0, 41)); cdb_ready = 1'b1;
    settle();
    check("fl_ready", PW'(src_ready), PW'(0));
    check("fl_xfer_src", PW'(cdb_src), PW'(1));
    check("fl_xfer_payload", cdb_payload, mk(1, 40));
    tick();
    flush = 1'b0; src_valid = '0; settle();
    check("fl_held_after", PW'(held_mask), PW'(0));
    check("fl_valid_after", PW'(cdb_valid), PW'(0));
`ifdef CDB_ARB_STATS_EN
    check("fl_conflict_cnt", PW'(conflict_cnt), PW'(1));
    check("fl_grant_cnt", PW'(grant_cnt), PW'(128'h0000_0000_0000_0000_0000_0001_0000_0000));
`endif
    tick(); settle();
    check("fl_src0_dropped", PW'(held_mask), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
